// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding and a round-robin pick helper for uart_tx_arbiter.
// rr_pick handles any request count up to MAX_REQ through its n argument.
package uart_tx_arbiter_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    // One-hot pick of the first valid index at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0]   live;
        logic [2*MAX_REQ-1:0] dbl;
        logic [2*MAX_REQ-1:0] masked;
        logic [2*MAX_REQ-1:0] lowest;
        live   = valid & ~({MAX_REQ{1'b1}} << n);
        dbl    = {{MAX_REQ{1'b0}}, live} | ({{MAX_REQ{1'b0}}, live} << n);
        masked = dbl & ({(2*MAX_REQ){1'b1}} << ptr);
        lowest = masked & (~masked + 1'b1);
        return lowest[MAX_REQ-1:0] | MAX_REQ'(lowest >> n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: one-hot first valid at or after ptr, wrapping.
// Zero latency, no flow control; an all-zero valid yields an all-zero grant.
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    localparam logic [2*NUM_REQ-1:0] ONES = '1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;
    logic [2*NUM_REQ-1:0] lowest;

    // Upper copy catches the wrap-around when nothing at or above ptr is valid.
    always_comb begin
        dbl    = {valid, valid};
        masked = dbl & (ONES << ptr);
        lowest = masked & (~masked + 1'b1);
        grant  = lowest[NUM_REQ-1:0] | lowest[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin share of one UART tx; grant 1 cycle after request, byte handed over combinationally.
// Stalls on uart_busy_i; with UART_TX_ARBITER_TIMEOUT_EN a grant stalled TIMEOUT_CYC cycles is revoked.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   uart_wr_o,
    output logic [7:0]             uart_tx_data_o,
    input  logic                   uart_busy_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   active_o
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt, pick;
    logic [PW-1:0]      rr_ptr, ptr_nxt, g_idx, g_after;
    logic               last_seen, last_nxt;
    logic               sel_valid, sel_last, accept, timed_out;
    logic [7:0]         sel_data;

    uart_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .grant (pick)
    );

    always_comb begin
        sel_data = '0;
        g_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | (req_data_i[8*i +: 8] & {8{grant_q[i]}});
            if (grant_q[i]) g_idx = PW'(i);
        end
    end

    assign sel_valid = |(req_valid_i & grant_q);
    assign sel_last  = |(req_last_i & grant_q);
    assign accept    = (state == SEND) && sel_valid && !uart_busy_i;
    assign g_after   = (g_idx == PW'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC+1);

    logic [CW-1:0] to_cnt, to_inc;

    assign to_inc    = to_cnt + 1'b1;
    assign timed_out = (state == SEND) && !sel_valid && (to_inc == CW'(TIMEOUT_CYC));

    // Counts only cycles where the owner has nothing to offer; a busy uart does not age the grant.
    always_ff @(posedge clk) begin
        if (reset_i || state == IDLE || accept) begin
            to_cnt <= '0;
        end else if (state == SEND && !sel_valid) begin
            to_cnt <= to_inc;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_q;
        ptr_nxt        = rr_ptr;
        last_nxt       = last_seen;
        uart_wr_o      = 1'b0;
        req_ready_o    = '0;
        uart_tx_data_o = '0;
        case (state)
            IDLE: begin
                if (|req_valid_i) begin
                    grant_nxt = pick;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    uart_wr_o      = 1'b1;
                    req_ready_o    = grant_q;
                    uart_tx_data_o = sel_data;
                    last_nxt       = sel_last;
                    state_nxt      = HOLD;
                end else if (timed_out) begin
                    grant_nxt = '0;
                    ptr_nxt   = g_after;
                    state_nxt = IDLE;
                end
            end
            // busy_o lags wr_i by a cycle, so busy is deliberately ignored here.
            HOLD: begin
                if (last_seen) begin
                    grant_nxt = '0;
                    ptr_nxt   = g_after;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SEND;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state     <= IDLE;
            grant_q   <= '0;
            rr_ptr    <= '0;
            last_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            rr_ptr    <= ptr_nxt;
            last_seen <= last_nxt;
        end
    end

    assign grant_o  = grant_q;
    assign active_o = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: message queues per requester, a round-robin
// service-order model and a busy-line model of the uart.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   req_valid_i, req_last_i, req_ready_o, grant_o;
    logic [8*N-1:0] req_data_i;
    logic           uart_wr_o, uart_busy_i, active_o;
    logic [7:0]     uart_tx_data_o;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_last_i     (req_last_i),
        .req_ready_o    (req_ready_o),
        .uart_wr_o      (uart_wr_o),
        .uart_tx_data_o (uart_tx_data_o),
        .uart_busy_i    (uart_busy_i),
        .grant_o        (grant_o),
        .active_o       (active_o)
    );

    always #5 clk = ~clk;

    logic [8:0] rq [N][$];      // per requester: {last, data}
    int         exp_req[$];
    logic [7:0] exp_dat[$];
    int         m_ptr;
    int         busy_cnt, busy_len;
    bit         gap_en;

    task automatic push_msg(input int n, input int len);
        for (int i = 0; i < len; i++)
            rq[n].push_back({(i == len-1), 8'($urandom)});
    endtask

    // Service order from the round-robin rule, whole messages at a time.
    task automatic build_expect();
        int pos[N];
        exp_req.delete();
        exp_dat.delete();
        for (int n = 0; n < N; n++) pos[n] = 0;
        while (1) begin
            int g;
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && pos[(m_ptr+k)%N] < rq[(m_ptr+k)%N].size()) g = (m_ptr+k)%N;
            if (g < 0) break;
            while (pos[g] < rq[g].size()) begin
                exp_req.push_back(g);
                exp_dat.push_back(rq[g][pos[g]][7:0]);
                pos[g]++;
                if (rq[g][pos[g]-1][8]) break;
            end
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic drive_inputs();
        for (int n = 0; n < N; n++) begin
            if (rq[n].size() > 0 && !(gap_en && grant_o[n] && $urandom_range(3) == 0)) begin
                req_valid_i[n]      = 1'b1;
                req_data_i[8*n +: 8] = rq[n][0][7:0];
                req_last_i[n]       = rq[n][0][8];
            end else begin
                req_valid_i[n]      = 1'b0;
                req_data_i[8*n +: 8] = 8'($urandom);
                req_last_i[n]       = 1'($urandom);
            end
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = (busy_cnt >= 1 && busy_cnt <= busy_len);
            #1;
            total++;
            if (uart_wr_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_wr: wr=%b, required 0 with nothing pending", uart_wr_o);
            end
            if (busy_cnt > 0) busy_cnt--;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        req_valid_i = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        m_ptr = 0;
        busy_cnt = 0;
    endtask

    task automatic run_stream(input string name, input int budget);
        int cyc;
        bit prev_wr;
        build_expect();
        cyc = 0;
        prev_wr = 1'b0;
        while (exp_dat.size() > 0 && cyc < budget) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = (busy_cnt >= 1 && busy_cnt <= busy_len);
            #1;
            cyc++;
            if (uart_wr_o) begin
                total++;
                if (uart_busy_i || prev_wr) begin
                    bad++;
                    $display("FAIL %s wr_timing: wr with busy=%b prev_wr=%b, required both 0", name, uart_busy_i, prev_wr);
                end
                total++;
                if (uart_tx_data_o !== exp_dat[0] || req_ready_o !== N'(1 << exp_req[0]) ||
                    grant_o !== N'(1 << exp_req[0])) begin
                    bad++;
                    $display("FAIL %s byte: got data=%h ready=%b grant=%b, required data=%h owner=%0d",
                             name, uart_tx_data_o, req_ready_o, grant_o, exp_dat[0], exp_req[0]);
                end
                for (int n = 0; n < N; n++)
                    if (req_valid_i[n] && req_ready_o[n]) void'(rq[n].pop_front());
                void'(exp_dat.pop_front());
                void'(exp_req.pop_front());
                busy_len = $urandom_range(12, 1);
                busy_cnt = busy_len + 1;
            end else begin
                total++;
                if (req_ready_o !== '0) begin
                    bad++;
                    $display("FAIL %s ready_no_wr: ready=%b, required 0", name, req_ready_o);
                end
                if (busy_cnt > 0) busy_cnt--;
            end
            prev_wr = uart_wr_o;
        end
        total++;
        if (exp_dat.size() > 0) begin
            bad++;
            $display("FAIL %s budget: %0d bytes still expected, required 0", name, exp_dat.size());
            for (int n = 0; n < N; n++) rq[n].delete();
        end
        idle_cycles(2);
        total++;
        if (grant_o !== '0 || active_o !== 1'b0) begin
            bad++;
            $display("FAIL %s release: grant=%b active=%b, required 0 0", name, grant_o, active_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            req_valid_i = '1;
            req_data_i  = {N{8'($urandom)}};
            req_last_i  = '1;
            uart_busy_i = 1'b0;
        end
        #1;
        total++;
        if (grant_o !== '0 || active_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: grant=%b active=%b, required 0 0", grant_o, active_o);
        end
        total++;
        if (uart_wr_o !== 1'b0 || req_ready_o !== '0 || uart_tx_data_o !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: wr=%b ready=%b data=%h, required 0 0 00", uart_wr_o, req_ready_o, uart_tx_data_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        req_valid_i = '0;
        m_ptr = 0;
        busy_cnt = 0;
    endtask

    task automatic test_single();
        gap_en = 1'b0;
        rq[0].push_back({1'b0, 8'h41});
        rq[0].push_back({1'b0, 8'h42});
        rq[0].push_back({1'b1, 8'h43});
        run_stream("single", 300);
    endtask

    task automatic test_pointer();
        rq[0].push_back({1'b1, 8'h50});
        rq[1].push_back({1'b1, 8'h51});
        run_stream("pointer", 300);
    endtask

    task automatic test_two();
        rq[0].push_back({1'b0, 8'h10});
        rq[0].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b1, 8'h20});
        run_stream("two_req", 300);
    endtask

    task automatic test_wrap();
        for (int n = 0; n < N; n++) rq[n].push_back({1'b1, 8'h60 + 8'(n)});
        run_stream("wrap", 300);
        rq[0].push_back({1'b1, 8'h70});
        rq[2].push_back({1'b1, 8'h72});
        run_stream("wrap_ptr", 300);
    endtask

    task automatic test_busy_hold();
        int owner;
        gap_en = 1'b0;
        rq[0].push_back({1'b0, 8'h5A});
        rq[0].push_back({1'b1, 8'hA5});
        build_expect();
        owner = exp_req[0];
        for (int c = 0; c < 51; c++) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = 1'b1;
            #1;
            total++;
            if (uart_wr_o !== 1'b0 || req_ready_o !== '0) begin
                bad++;
                $display("FAIL busy_stall cycle %0d: wr=%b ready=%b, required 0 0", c, uart_wr_o, req_ready_o);
            end
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = 1'b0;
            #1;
            total++;
            if (uart_wr_o !== 1'b1 || req_ready_o !== N'(1 << owner) || uart_tx_data_o !== exp_dat[b]) begin
                bad++;
                $display("FAIL busy_release byte %0d: wr=%b ready=%b data=%h, required 1 %b %h",
                         b, uart_wr_o, req_ready_o, uart_tx_data_o, N'(1 << owner), exp_dat[b]);
            end
            if (req_ready_o[0]) void'(rq[0].pop_front());
            @(negedge clk);
            drive_inputs();
            uart_busy_i = 1'b0;
            #1;
            total++;
            if (uart_wr_o !== 1'b0 || req_ready_o !== '0 || grant_o !== N'(1 << owner) || active_o !== 1'b1) begin
                bad++;
                $display("FAIL hold_cycle byte %0d: wr=%b ready=%b grant=%b active=%b, required 0 0 %b 1",
                         b, uart_wr_o, req_ready_o, grant_o, active_o, N'(1 << owner));
            end
        end
        exp_dat.delete();
        exp_req.delete();
        rq[0].delete();
        busy_cnt = 0;
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        bit found;
        gap_en = 1'b0;
        found = 1'b0;
        rq[1].push_back({1'b1, 8'h77});
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = 1'b1;
            #1;
            if (grant_o !== '0) found = 1'b1;
        end
        total++;
        if (grant_o !== 3'b010) begin
            bad++;
            $display("FAIL reset_mid_grant: grant=%b, required 010", grant_o);
        end
        @(negedge clk);
        drive_inputs();
        uart_busy_i = 1'b0;
        reset_i = 1'b1;
        #1;
        total++;
        if (uart_wr_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_wr: wr=%b, required 1 in the reset cycle", uart_wr_o);
        end
        rq[1].delete();
        @(negedge clk);
        reset_i = 1'b0;
        drive_inputs();
        #1;
        total++;
        if (grant_o !== '0 || active_o !== 1'b0 || req_ready_o !== '0 || uart_wr_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after: grant=%b active=%b ready=%b wr=%b, required all 0",
                     grant_o, active_o, req_ready_o, uart_wr_o);
        end
        m_ptr = 0;
        busy_cnt = 0;
    endtask

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int  held;
        bit  done;
        do_reset();
        gap_en = 1'b0;
        done = 1'b0;
        rq[1].push_back({1'b0, 8'h31});
        rq[2].push_back({1'b1, 8'h32});
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = 1'b0;
            #1;
            if (uart_wr_o && req_ready_o[1]) begin
                void'(rq[1].pop_front());
                done = 1'b1;
            end
        end
        held = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = 1'b0;
            #1;
            if (grant_o === 3'b010 && !uart_wr_o) held++;
            else done = 1'b1;
        end
        total++;
        if (held != TO + 1) begin
            bad++;
            $display("FAIL timeout_hold: grant held %0d cycles after the byte, required %0d (hold + %0d stalls)", held, TO + 1, TO);
        end
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            drive_inputs();
            uart_busy_i = 1'b0;
            #1;
            if (uart_wr_o) begin
                done = 1'b1;
                total++;
                if (req_ready_o !== 3'b100 || uart_tx_data_o !== 8'h32) begin
                    bad++;
                    $display("FAIL timeout_next: ready=%b data=%h, required 100 32", req_ready_o, uart_tx_data_o);
                end
                if (req_ready_o[2]) void'(rq[2].pop_front());
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout_next: no write from requester 2 within budget, required one");
        end
        for (int n = 0; n < N; n++) rq[n].delete();
        do_reset();
    endtask
`endif

    task automatic test_random();
        gap_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < N; n++) begin
                int msgs;
                msgs = $urandom_range(2, 0);
                for (int m = 0; m < msgs; m++) push_msg(n, $urandom_range(4, 1));
            end
            run_stream("random", 3000);
        end
        gap_en = 1'b0;
    endtask

    initial begin
        reset_i     = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        uart_busy_i = 1'b0;
        gap_en      = 1'b0;
        busy_cnt    = 0;
        busy_len    = 0;
        m_ptr       = 0;
        test_reset();
        test_single();
        test_pointer();
        do_reset();
        test_two();
        test_wrap();
        test_busy_hold();
        test_reset_mid();
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte-stream requesters, for example a debug console, a CPU mailbox and a trace unit.
- Round-robin arbitration between requesters.
- Message locking: a grant is held from a requester's first byte through the byte flagged last, so messages never interleave on the serial line.
- Sits between the requesters and the uart instance; drives its wr_i/tx_data_i and watches busy_o.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYC, 4096, idle cycles a locked requester may stall before its grant is revoked (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_i  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  requester n has a byte on req_data_i[8n+7:8n]
req_data_i  in  8*NUM_REQ  packed byte per requester
req_last_i  in  NUM_REQ  byte is the final byte of its message
req_ready_o  out  NUM_REQ  byte of requester n accepted this cycle
uart_wr_o  out  1  write strobe to uart wr_i
uart_tx_data_o  out  8  byte to uart tx_data_i
uart_busy_i  in  1  uart busy_o
grant_o  out  NUM_REQ  one-hot current owner; 0 when idle
active_o  out  1  a message is in progress (state != IDLE)

Behaviour:
Clock and reset
- One clock (clk). reset_i is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_o=0, active_o=0, uart_wr_o=0, req_ready_o=0, uart_tx_data_o=0.

States
- IDLE: if any req_valid_i is high, pick the first valid index at or after rr_ptr, wrapping modulo NUM_REQ. Register the one-hot grant and go to SEND. No byte is accepted in the grant cycle.
- SEND, when valid[g]=1 and uart_busy_i=0:
  - uart_wr_o=1 and req_ready_o[g]=1 combinationally in the same cycle; uart_tx_data_o = data[g], also combinational.
  - Register last_seen = req_last_i[g], then go to HOLD.
- SEND, otherwise: stay in SEND with outputs 0.
- HOLD: exactly one cycle. It covers the uart's one-cycle lag between wr and busy rising; the arbiter must not sample uart_busy_i in this cycle.
  - If last_seen=1: set rr_ptr=(g+1) mod NUM_REQ, grant_o=0, go to IDLE.
  - Otherwise go back to SEND.

Throughput
- At most one byte per uart frame.
- The uart is busy for about 15 bit times after its own reset; the arbiter only waits on busy and takes no other action.

Rules
- Handshake: a byte transfers when req_valid_i[n] & req_ready_o[n]. Requesters must hold data and last stable while valid is high.
- req_ready_o is never high for a requester other than the granted one. At most one ready bit is high per cycle.
- A single-byte message (last set on the first byte) releases the grant after HOLD.
- Other requesters' valid bits are ignored while a grant is locked.
- Simultaneous requests in IDLE: rr_ptr priority. Example: rr_ptr=2 with requests 0 and 2 gives grant 2.
- The pointer wraps: after g=NUM_REQ-1, rr_ptr=0.
- Granted requester drops valid mid-message: the grant is held indefinitely (unless the optional feature is compiled in).
- reset_i mid-message: immediate return to reset values. Any partially sent byte is the uart's own concern.

Optional Feature:
Macro UART_TX_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) increments each SEND cycle in which valid[g]=0.
  - The counter clears on each accepted byte and on grant.
  - When it reaches TIMEOUT_CYC: release the grant, advance rr_ptr past g, go to IDLE.
  - The message is abandoned and no terminating byte is injected.
- Undefined: no counter logic exists; the grant is held until last.

Decomposition:
- Package uart_tx_arbiter_pkg:
  - state enum {IDLE, SEND, HOLD} as logic [1:0];
  - function rr_pick(valid, ptr) returning a one-hot vector.
- Sub-module uart_rr_pick: combinational round-robin priority selector, parameterised by NUM_REQ, using a double-width mask technique.
- The top file holds the FSM, pointer, data mux and timeout counter.

Test Plan:
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) into the real uart at divider 104 -> tx line shows the 3 frames in order; grant_o=3'b001 throughout, then 0; rr_ptr=1.
- Requesters 0 and 1 request together from reset -> requester 0's whole message 0x10,0x11 (last) completes before requester 1's 0x20; no req_ready_o[1] during requester 0's grant.
- rr_ptr=2 with all three requesting single-byte messages -> service order 2,0,1; pointer wraps to 2.
- uart_busy_i forced high for 50 cycles in SEND -> uart_wr_o stays 0 and the byte is held; after busy falls, exactly one wr pulse and one ready pulse in the same cycle, then one HOLD cycle with no wr.
- reset_i asserted in the cycle a wr is issued -> next cycle: grant_o=0, active_o=0, all ready 0.
- With UART_TX_ARBITER_TIMEOUT_EN and TIMEOUT_CYC=16: requester 1 sends a non-last byte then drops valid -> grant released after 16 stalled cycles; pending requester 2 is granted next.
